// File: rtl/wide_add_pkg.sv
// Shared types and constants for the sliced wide adder: slice width, FSM
// states and the index-counter width helper.
package wide_add_pkg;

   localparam int SLICE_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A single-slice build still needs a 1-bit index register.
   function automatic int idx_w(input int slices);
      return (slices > 1) ? $clog2(slices) : 1;
   endfunction

endpackage

// File: rtl/cla16_slice.sv
// Combinational 16-bit carry-lookahead adder slice: four 4-bit lookahead
// groups joined by a second-level 4-group lookahead unit.
module cla16_slice (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout,
   output logic        c15
);

   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [3:0]  grp_g;
   logic [3:0]  grp_p;
   logic [3:0]  grp_c;

   assign g = a & b;
   assign p = a ^ b;

   for (genvar gi = 0; gi < 4; gi++) begin : g_group
      localparam int B = 4 * gi;
      assign c[B]     = grp_c[gi];
      assign c[B + 1] = g[B] | (p[B] & grp_c[gi]);
      assign c[B + 2] = g[B + 1] | (p[B + 1] & g[B]) | (p[B + 1] & p[B] & grp_c[gi]);
      assign c[B + 3] = g[B + 2] | (p[B + 2] & g[B + 1]) | (p[B + 2] & p[B + 1] & g[B])
                      | (p[B + 2] & p[B + 1] & p[B] & grp_c[gi]);
      assign grp_g[gi] = g[B + 3] | (p[B + 3] & g[B + 2]) | (p[B + 3] & p[B + 2] & g[B + 1])
                       | (p[B + 3] & p[B + 2] & p[B + 1] & g[B]);
      assign grp_p[gi] = &p[B +: 4];
   end

   // Second level: group carries computed directly from group generate/propagate.
   assign grp_c[0] = cin;
   assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
   assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
   assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
   assign cout     = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                   | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

   assign sum = p ^ c;
   assign c15 = c[15];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder/subtractor: one 16-bit lookahead slice per cycle,
// LSB slice first, carry chained through a register between slices.
module wide_add_sequencer
   import wide_add_pkg::*;
#(
   parameter int SLICES = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SLICE_W*SLICES-1:0] in_a,
   input  logic [SLICE_W*SLICES-1:0] in_b,
   input  logic                      in_cin,
   input  logic                      in_sub,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SLICE_W*SLICES-1:0] out_sum,
   output logic                      out_cout,
   output logic                      out_ovf,
   output logic                      busy
);

   localparam int W     = SLICE_W * SLICES;
   localparam int IDX_W = idx_w(SLICES);

   state_t             state_q;
   logic [W-1:0]       a_q;
   logic [W-1:0]       b_q;
   logic [W-1:0]       sum_q;
   logic               carry_q;
   logic [IDX_W-1:0]   idx_q;
   logic               in_ready_q;
   logic               cout_q;
   logic               ovf_q;

   logic [SLICE_W-1:0] a_sl [SLICES];
   logic [SLICE_W-1:0] b_sl [SLICES];
   logic [SLICE_W-1:0] slice_a;
   logic [SLICE_W-1:0] slice_b;
   logic [SLICE_W-1:0] slice_sum;
   logic               slice_cout;
   logic               slice_c15;
   logic               last_slice;

   for (genvar gi = 0; gi < SLICES; gi++) begin : g_view
      assign a_sl[gi] = a_q[gi*SLICE_W +: SLICE_W];
      assign b_sl[gi] = b_q[gi*SLICE_W +: SLICE_W];
   end

   assign slice_a    = a_sl[idx_q];
   assign slice_b    = b_sl[idx_q];
   assign last_slice = (idx_q == IDX_W'(SLICES - 1));

   cla16_slice u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout),
      .c15  (slice_c15)
   );

   // Subtraction is A + ~B + 1, so B is inverted once at accept time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         sum_q      <= '0;
         carry_q    <= 1'b0;
         idx_q      <= '0;
         in_ready_q <= 1'b0;
         cout_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= in_a;
                  b_q        <= in_sub ? ~in_b : in_b;
                  carry_q    <= in_sub | in_cin;
                  idx_q      <= '0;
                  state_q    <= RUN;
                  in_ready_q <= 1'b0;
               end else begin
                  in_ready_q <= 1'b1;
               end
            end
            RUN: begin
               sum_q[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
               carry_q    <= slice_cout;
               idx_q      <= idx_q + 1'b1;
               in_ready_q <= 1'b0;
               if (last_slice) begin
                  cout_q  <= slice_cout;
                  ovf_q   <= slice_c15 ^ slice_cout;
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q    <= IDLE;
                  in_ready_q <= 1'b1;
               end else begin
                  in_ready_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= IDLE;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q == DONE);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign out_ovf   = ovf_q;
   assign busy      = (state_q != IDLE);

endmodule
